// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment scanner with per-slot brightness PWM
// and a double-buffered frame that swaps only at frame boundaries.
module seg_scan #(
   parameter int STEP  = 64,
   parameter int BLANK = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] segs_i [8],
   input  logic       load_i,
   input  logic [3:0] brightness_i,
   output logic [7:0] seg_o,
   output logic [7:0] an_o,
   output logic       pending_o,
   output logic       frame_done_o
);

   localparam int SLOT = BLANK + 16 * STEP;
   localparam int CW   = (SLOT > 1) ? $clog2(SLOT) : 1;
   localparam int LW   = $clog2(SLOT + 1) + 1;

   typedef enum logic [1:0] {
      ST_BLANK,
      ST_ON,
      ST_OFF
   } state_t;

   state_t         state_q, state_n;
   logic [CW-1:0]  c_q, c_n;
   logic [2:0]     d_q, d_n;
   logic [3:0]     b_q, b_n;
   logic [LW-1:0]  on_end;
   logic           slot_last;
   logic           boundary;
   logic           pending_q;
   logic [7:0]     shadow_q [8];
   logic [7:0]     active_q [8];

   always_comb begin
      slot_last = (c_q == CW'(SLOT - 1));
      boundary  = slot_last && (d_q == 3'd7);
      c_n       = slot_last ? '0 : c_q + 1'b1;
      d_n       = slot_last ? d_q + 3'd1 : d_q;
      // brightness is latched while the slot sits at c==0 and governs c>=1
      b_n       = (c_q == '0) ? brightness_i : b_q;
      on_end    = LW'(BLANK) + LW'({1'b0, b_n} + 5'd1) * LW'(STEP);
      state_n   = ST_OFF;
      if (LW'(c_n) < LW'(BLANK)) begin
         state_n = ST_BLANK;
      end else if (LW'(c_n) < on_end) begin
         state_n = ST_ON;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_BLANK;
         c_q     <= '0;
         d_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_n;
         c_q     <= c_n;
         d_q     <= d_n;
         b_q     <= b_n;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         an_o  <= '1;
         seg_o <= '1;
      end else if (state_q == ST_ON) begin
         an_o  <= ~(8'd1 << d_q);
         seg_o <= active_q[d_q];
      end else begin
         an_o  <= '1;
         seg_o <= '1;
      end
   end

   // Swap reads the old shadow, so a load on the boundary lands one frame later
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pending_q <= 1'b0;
         for (int unsigned i = 0; i < 8; i++) begin
            shadow_q[i] <= '1;
            active_q[i] <= '1;
         end
      end else begin
         if (load_i) begin
            pending_q <= 1'b1;
         end else if (boundary) begin
            pending_q <= 1'b0;
         end
         for (int unsigned i = 0; i < 8; i++) begin
            if (boundary && pending_q) begin
               active_q[i] <= shadow_q[i];
            end
            if (load_i) begin
               shadow_q[i] <= segs_i[i];
            end
         end
      end
   end

   assign pending_o    = pending_q;
   assign frame_done_o = boundary;

endmodule
